timekeeper: RTL and testbench
=============================

// Module: timekeeper
// PURPOSE
//  Real-time 12-hour clock; drives clock_hr/clock_min into alarm and hexdisplay.
//  Counts seconds from a CLOCK_50 prescaler and rolls over minutes, hours and AM/PM.
//  Time is set with the hour/minute keys while clock_set is high.
//  Key inputs arrive raw (active-high, already inverted at top level).
// PARAMETERS
//  TICK_DIV       50_000_000  clock cycles per second
//  REPEAT_CYCLES  25_000_000  hold time before first auto-repeat, and between repeats
// PORTS
//  clock       in   1  system clock (CLOCK_50)
//  reset       in   1  synchronous, active-high reset
//  clock_set   in   1  1 = set mode (keys active, seconds frozen)
//  hrKEY       in   1  hour increment key, active-high, asynchronous
//  minKEY      in   1  minute increment key, active-high, asynchronous
//  clock_hr    out  4  hour, 1..12
//  clock_min   out  6  minute, 0..59
//  clock_sec   out  6  second, 0..59
//  pm          out  1  0 = AM, 1 = PM
//  sec_tick    out  1  one-cycle pulse when the prescaler completes a second (run mode only)
//  min_tick    out  1  one-cycle pulse when a timekeeping rollover changes clock_min
// BEHAVIOUR
//  Reset values:
//   - clock_hr=12, clock_min=0, clock_sec=0, pm=0; sec_tick=0, min_tick=0.
//   - Prescaler, synchronisers and key FSMs cleared.
//  Prescaler: counts 0..TICK_DIV-1; sec_tick=1 in the cycle it wraps to 0.
//  Run mode (clock_set=0):
//   - Keys ignored.
//   - On sec_tick: sec+1. sec 59->0 carries into min; min 59->0 carries into hr.
//   - hr 12->1; hr 11->12 toggles pm.
//   - min_tick asserts in the same cycle clock_min updates.
//  Set mode (clock_set=1):
//   - Prescaler and clock_sec held at 0; sec_tick=0, min_tick=0.
//   - Each key increment pulse: min 59->0 with NO carry into hr.
//   - hr 12->1; hr 11->12 toggles pm.
//  Mode change:
//   - Entering set mode clears prescaler and sec in the next cycle.
//   - Leaving set mode starts a fresh full second (first sec_tick TICK_DIV cycles later).
//  Key path: 2-flop synchroniser, then the key_repeat FSM per key.
//   - IDLE: key high -> emit pulse, go to HOLD, clear counter.
//   - HOLD: key low -> IDLE; counter reaches REPEAT_CYCLES-1 -> emit pulse, clear counter, stay in HOLD.
//   - Pulse is one cycle wide.
//   - Latency: registers update on the 4th rising edge after the key first samples high
//     (2 sync + FSM + update).
//   - Key FSMs run in both modes; their pulses are discarded in run mode.
//     A key held across entry to set mode produces no pulse until released and re-pressed.
//  Simultaneous events:
//   - hr and min pulses in the same cycle both apply.
//   - A sec_tick coinciding with clock_set rising is discarded.
//  Reset mid-operation: reset wins over every other event in that cycle.
//  Widths: all increments use compare-to-max then load; no modulo arithmetic.
//  Out-of-range values are unreachable.
// STRUCTURE
//  - Shared header clock_defs.vh, also used by alarm: HR_FIRST=1, HR_LAST=12,
//    MIN_LAST=59, SEC_LAST=59, HR_W=4, MIN_W=6.
//  - One sub-module, key_repeat (synchroniser + IDLE/HOLD FSM + repeat counter),
//    instantiated for hrKEY and minKEY.
// TESTING (TICK_DIV=4, REPEAT_CYCLES=8)
//  1. Reset, run mode, 240 cycles -> clock_sec 0->59->0; min_tick once; clock 12:01:00 AM.
//  2. Preload 11:59:59 AM, one sec_tick -> 12:00:00, pm=1, min_tick=1 for one cycle.
//     Then preload 12:59:59 -> 1:00:00, pm unchanged.
//  3. Set mode, minKEY pulsed high for 1 cycle, min=59 -> min=0, hr unchanged,
//     update on the 4th edge after the key rises.
//  4. Set mode, hrKEY held 30 cycles from 12 AM -> 4 increments (initial + 3 repeats);
//     hr passes 12->1->2->3->4, pm=0.
//  5. hrKEY and minKEY rise in the same cycle at 11:59 AM -> 12:00 PM in a single update.
//  6. Reset asserted in the cycle of a sec_tick at 11:59:59 PM -> 12:00:00 AM;
//     no min_tick; prescaler restarts from 0.

Source files
------------

// File: rtl/timekeeper_pkg.sv
// Shared time-of-day limits and widths for the 12-hour clock, its alarm and display.
// Also holds the key auto-repeat state encoding.
package timekeeper_pkg;

  localparam int HR_FIRST = 1;
  localparam int HR_LAST  = 12;
  localparam int MIN_LAST = 59;
  localparam int SEC_LAST = 59;
  localparam int HR_W     = 4;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;

  typedef enum logic {
    KR_IDLE = 1'b0,
    KR_HOLD = 1'b1
  } kr_state_e;

endpackage

// File: rtl/timekeeper_key_repeat.sv
// Raw key -> 2-flop synchroniser -> IDLE/HOLD auto-repeat FSM -> registered one-cycle pulse.
// Pulses are suppressed for a press that began or continued while en was low.
module key_repeat
  import timekeeper_pkg::*;
#(
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic key,
  output logic pulse
);

  localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic             key_p0;
  logic             key_p1;
  kr_state_e        state;
  kr_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             fire;
  logic             muted;

  // stage p0/p1: synchroniser
  always_ff @(posedge clock) begin
    if (reset) begin
      key_p0 <= 1'b0;
      key_p1 <= 1'b0;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= KR_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      KR_IDLE: if (key_p1)  state_nxt = KR_HOLD;
      KR_HOLD: if (!key_p1) state_nxt = KR_IDLE;
      default:              state_nxt = KR_IDLE;
    endcase
  end

  always_comb begin
    fire = 1'b0;
    case (state)
      KR_IDLE: fire = key_p1;
      KR_HOLD: fire = key_p1 && (cnt == CNT_W'(REPEAT_CYCLES - 1));
      default: fire = 1'b0;
    endcase
  end

  // stage p2: repeat counter, mute flag and registered pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      muted <= 1'b0;
      pulse <= 1'b0;
    end else begin
      if (state == KR_IDLE || fire) cnt <= '0;
      else                          cnt <= cnt + CNT_W'(1);
      // a press seen while disabled stays silent until the key is released
      if (state_nxt == KR_IDLE) muted <= 1'b0;
      else if (!en)             muted <= 1'b1;
      pulse <= fire && en && !muted;
    end
  end

endmodule

// File: rtl/timekeeper.sv
// 12-hour real-time clock: prescaled seconds with minute/hour/AM-PM rollover,
// plus a set mode where the hour/minute keys step the time.
module timekeeper
  import timekeeper_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clock_set,
  input  logic             hrKEY,
  input  logic             minKEY,
  output logic [HR_W-1:0]  clock_hr,
  output logic [MIN_W-1:0] clock_min,
  output logic [SEC_W-1:0] clock_sec,
  output logic             pm,
  output logic             sec_tick,
  output logic             min_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          hr_pulse;
  logic          min_pulse;
  logic          sec_wrap;
  logic          min_wrap;
  logic          min_inc;
  logic          hr_inc;

  function automatic logic [HR_W-1:0] next_hr(input logic [HR_W-1:0] hr);
    return (hr == HR_W'(HR_LAST)) ? HR_W'(HR_FIRST) : hr + HR_W'(1);
  endfunction

  function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
    return (m == MIN_W'(MIN_LAST)) ? '0 : m + MIN_W'(1);
  endfunction

  function automatic logic [SEC_W-1:0] next_sec(input logic [SEC_W-1:0] s);
    return (s == SEC_W'(SEC_LAST)) ? '0 : s + SEC_W'(1);
  endfunction

  key_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_hr_key (
    .clock (clock),
    .reset (reset),
    .en    (clock_set),
    .key   (hrKEY),
    .pulse (hr_pulse)
  );

  key_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_min_key (
    .clock (clock),
    .reset (reset),
    .en    (clock_set),
    .key   (minKEY),
    .pulse (min_pulse)
  );

  // gating on clock_set also discards a tick that lands on set-mode entry
  assign sec_tick = !reset && !clock_set && (presc == PW'(TICK_DIV - 1));
  assign sec_wrap = (clock_sec == SEC_W'(SEC_LAST));
  assign min_wrap = (clock_min == MIN_W'(MIN_LAST));
  assign min_tick = sec_tick && sec_wrap;

  // set-mode minute steps never carry into the hour
  assign min_inc = min_tick || (clock_set && min_pulse);
  assign hr_inc  = (min_tick && min_wrap) || (clock_set && hr_pulse);

  always_ff @(posedge clock) begin
    if (reset) begin
      presc     <= '0;
      clock_sec <= '0;
      clock_min <= '0;
      clock_hr  <= HR_W'(HR_LAST);
      pm        <= 1'b0;
    end else begin
      if (clock_set || presc == PW'(TICK_DIV - 1)) presc <= '0;
      else                                         presc <= presc + PW'(1);
      if (clock_set)     clock_sec <= '0;
      else if (sec_tick) clock_sec <= next_sec(clock_sec);
      if (min_inc) clock_min <= next_min(clock_min);
      if (hr_inc) begin
        clock_hr <= next_hr(clock_hr);
        if (clock_hr == HR_W'(HR_LAST - 1)) pm <= !pm;
      end
    end
  end

endmodule

// File: tb/tb_timekeeper.sv
// Directed bench for timekeeper with a 4-cycle second and 8-cycle key repeat.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_timekeeper;
  import timekeeper_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             clock_set;
  logic             hrKEY;
  logic             minKEY;
  logic [HR_W-1:0]  clock_hr;
  logic [MIN_W-1:0] clock_min;
  logic [SEC_W-1:0] clock_sec;
  logic             pm;
  logic             sec_tick;
  logic             min_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int mt_count;
  int saw59;

  timekeeper #(.TICK_DIV(4), .REPEAT_CYCLES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .clock_set (clock_set),
    .hrKEY     (hrKEY),
    .minKEY    (minKEY),
    .clock_hr  (clock_hr),
    .clock_min (clock_min),
    .clock_sec (clock_sec),
    .pm        (pm),
    .sec_tick  (sec_tick),
    .min_tick  (min_tick)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int p);
    chk({tag, ".hr"},  32'(clock_hr),  32'(h));
    chk({tag, ".min"}, 32'(clock_min), 32'(m));
    chk({tag, ".sec"}, 32'(clock_sec), 32'(s));
    chk({tag, ".pm"},  32'(pm),        32'(p));
  endtask

  task automatic press(input logic h, input logic m);
    hrKEY  = h;
    minKEY = m;
    step(1);
    hrKEY  = 1'b0;
    minKEY = 1'b0;
    step(4);
  endtask

  initial begin
    reset = 1'b1; clock_set = 1'b0; hrKEY = 1'b0; minKEY = 1'b0;
    step(2);
    chk_time("reset", 12, 0, 0, 0);
    chk("reset.sec_tick", 32'(sec_tick), 0);
    chk("reset.min_tick", 32'(min_tick), 0);
    reset = 1'b0;

    // one full minute of run mode
    mt_count = 0;
    saw59 = 0;
    for (int i = 1; i <= 240; i++) begin
      step(1);
      if (min_tick) mt_count++;
      if (clock_sec == 6'd59) saw59 = 1;
      if (i == 2) chk("run.first_tick_early", 32'(sec_tick), 0);
      if (i == 3) chk("run.first_tick", 32'(sec_tick), 1);
    end
    chk("run.min_tick_count", 32'(mt_count), 1);
    chk("run.saw_sec59", 32'(saw59), 1);
    chk_time("run.minute", 12, 1, 0, 0);

    // keys ignored in run mode
    press(1'b1, 1'b1);
    chk("run.key_ignored.min", 32'(clock_min), 1);
    chk("run.key_ignored.hr", 32'(clock_hr), 12);

    // key held across entry to set mode stays silent
    minKEY = 1'b1;
    step(3);
    clock_set = 1'b1;
    step(20);
    chk_time("held_entry", 12, 1, 0, 0);
    chk("held_entry.sec_tick", 32'(sec_tick), 0);
    minKEY = 1'b0;
    step(3);

    // minute 59 -> 0 without hour carry, 4-edge latency
    repeat (58) press(1'b0, 1'b1);
    chk("set.min59", 32'(clock_min), 59);
    minKEY = 1'b1;
    step(1);
    minKEY = 1'b0;
    step(2);
    chk("set.min_edge3", 32'(clock_min), 59);
    step(1);
    chk_time("set.min_edge4", 12, 0, 0, 0);
    step(2);

    // hour key held 30 cycles: initial pulse + 3 repeats
    hrKEY = 1'b1;
    step(4);
    chk("hold.hr_edge4", 32'(clock_hr), 1);
    step(8);
    chk("hold.hr_edge12", 32'(clock_hr), 2);
    step(18);
    chk("hold.hr_edge30", 32'(clock_hr), 4);
    hrKEY = 1'b0;
    step(6);
    chk_time("hold.final", 4, 0, 0, 0);

    // 11:59:59 AM -> 12:00:00 PM
    repeat (7) press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    chk_time("noon.setup", 11, 59, 0, 0);
    clock_set = 1'b0;
    step(236);
    chk_time("noon.pre", 11, 59, 59, 0);
    step(3);
    chk("noon.sec_tick", 32'(sec_tick), 1);
    chk("noon.min_tick", 32'(min_tick), 1);
    step(1);
    chk_time("noon.post", 12, 0, 0, 1);
    chk("noon.min_tick_off", 32'(min_tick), 0);

    // 12:59:59 PM -> 1:00:00 PM
    step(14396);
    chk_time("one.pre", 12, 59, 59, 1);
    step(4);
    chk_time("one.post", 1, 0, 0, 1);

    // reset on a tick at 11:59:59 PM
    clock_set = 1'b1;
    step(1);
    chk("set.sec_cleared", 32'(clock_sec), 0);
    repeat (10) press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    chk_time("midnight.setup", 11, 59, 0, 1);
    clock_set = 1'b0;
    step(236);
    chk_time("midnight.pre", 11, 59, 59, 1);
    step(3);
    chk("midnight.tick_due", 32'(sec_tick), 1);
    reset = 1'b1;
    #1;
    chk("rst_tick.sec_tick", 32'(sec_tick), 0);
    chk("rst_tick.min_tick", 32'(min_tick), 0);
    step(1);
    chk_time("rst_tick.post", 12, 0, 0, 0);
    reset = 1'b0;
    step(2);
    chk("rst_tick.presc2", 32'(sec_tick), 0);
    step(1);
    chk("rst_tick.presc3", 32'(sec_tick), 1);
    step(1);
    chk("rst_tick.sec1", 32'(clock_sec), 1);

    // both keys at 11:59 AM -> 12:00 PM in one update
    clock_set = 1'b1;
    step(1);
    repeat (11) press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    chk_time("both.setup", 11, 59, 0, 0);
    hrKEY  = 1'b1;
    minKEY = 1'b1;
    step(1);
    hrKEY  = 1'b0;
    minKEY = 1'b0;
    step(2);
    chk_time("both.edge3", 11, 59, 0, 0);
    step(1);
    chk_time("both.edge4", 12, 0, 0, 1);
    chk("both.sec_tick", 32'(sec_tick), 0);
    step(4);
    chk_time("both.settled", 12, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
